tag_free_list: RTL and testbench
================================

# tag_free_list

32-entry tag allocator that owns the free mask for a 32-tag pool (ROB/RS/physical-register tags). It feeds the free mask into the lowest-index-first 32:5 priority encoder (`per32_5`) and offers that tag to the rename/issue stage through an alloc handshake. It also accepts tag returns from retire/writeback and a full flush. The mask, busy counter and error flag are registered; the tag offer is combinational from registered state.

## Interface
- `RESET_FREE_MASK`, default 32'hFFFF_FFFF: free mask loaded on reset and flush; bit i = 1 means tag i is free.
- `CLK` in 1: single clock, all state updates on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `alloc_req` in 1: consumer takes the offered tag this cycle.
- `alloc_ready` out 1: at least one tag is free (encoder valid).
- `alloc_tag` out 5: lowest-index free tag; valid only when `alloc_ready`=1.
- `free_valid` in 1: return `free_tag` to the pool.
- `free_tag` in 5: tag being returned.
- `flush` in 1: reload the free mask with `RESET_FREE_MASK`.
- `busy_count` out 6: number of tags in use, 0..32.
- `full` out 1: `busy_count`==32.
- `err` out 1: sticky protocol error (see Configuration).

## Operation
- State: `free_mask[31:0]`, `busy_count[5:0]`, `err`.
- Reset (`RST`=1 at edge): `free_mask`=`RESET_FREE_MASK`; `busy_count`=32 − popcount(`RESET_FREE_MASK`), an elaboration-time constant; `err`=0.
- `alloc_tag`/`alloc_ready` come from `per32_5` on `free_mask`. `alloc_tag` = index of the lowest set bit. `alloc_ready` = OR of the mask.
- Alloc fire = `alloc_req` & `alloc_ready`. On fire, clear `free_mask[alloc_tag]` and increment `busy_count`. `alloc_req` with `alloc_ready`=0 is ignored: no state change.
- Free fire = `free_valid`. Set `free_mask[free_tag]` and decrement `busy_count`. A freed tag is not offered until the next cycle; there is no same-cycle bypass.
- Alloc and free in the same cycle with different tags: both apply and `busy_count` is unchanged.
- Alloc and free of the same tag in the same cycle: this only arises from a double free. Free wins (bit ends at 1) and `busy_count` is unchanged.
- Free of a tag whose mask bit is already 1 (double free): mask unchanged and `busy_count` not decremented; flagged per Configuration.
- `flush`: `free_mask`=`RESET_FREE_MASK` and `busy_count` = its reset value. Alloc and free in the same cycle are discarded. `err` is unchanged.
- Priority at the edge: `RST` > `flush` > alloc/free.
- `busy_count` never wraps: it saturates logically because alloc is blocked at 32 and double frees do not decrement.

## Timing
- Offer latency: combinational from registered mask. After an alloc fire at edge N, the next lowest free tag appears after edge N (1 cycle).
- Free-to-reuse latency: a tag freed at edge N is offerable in cycle N+1.
- `busy_count`, `full` and `err` are registered and reflect events of the previous edge.
- Throughput: one alloc and one free per cycle.
- `RST` or `flush` asserted mid-stream: takes effect at that edge. Outputs in the following cycle reflect the reset mask (`alloc_tag`=lowest set bit of `RESET_FREE_MASK`).

## Configuration
- `TAG_FREE_LIST_CHECK_EN` defined:
  - double free sets sticky `err`=1;
  - `alloc_req` while `alloc_ready`=0 sets `err`=1;
  - `err` clears only on `RST`.
- Not defined: `err` is tied to 0. Both conditions are silently ignored as described in Operation.

## Test plan
- Reset with default mask, then `alloc_req`=1 for 32 cycles:
  - tags 0,1,…,31 are issued in order;
  - `busy_count` reaches 32 and `full`=1;
  - cycle 33 gives `alloc_ready`=0.
- From full, free tag 7:
  - the next cycle offers `alloc_tag`=7 and `busy_count`=31;
  - alloc plus free of tag 3 in the same cycle leaves `busy_count` at 31.
- Alloc (offer 5) and free of tag 2 in the same cycle with tags 0–4 busy:
  - the mask has bit 5=0 and bit 2=1;
  - the next offer is 2 and `busy_count` is unchanged.
- Double free of tag 9 while it is free:
  - mask and `busy_count` are unchanged;
  - with `TAG_FREE_LIST_CHECK_EN`, `err`=1 next cycle and stays set through a flush;
  - without the macro, `err`=0.
- `RESET_FREE_MASK`=32'hFFFF_FF00:
  - after reset, `busy_count`=8 and `alloc_tag`=8;
  - after 10 allocs and a `flush` asserted together with `alloc_req`, the next cycle shows `busy_count`=8 and `alloc_tag`=8.
- Mid-stream `RST` while `free_valid`=1 and `alloc_req`=1: all state returns to reset values and neither event applies.

Source files
------------

// File: rtl/tag_free_list.sv
// 32-entry tag allocator: free mask, lowest-index-first offer, returns and flush.
// Optional protocol checking (sticky err) enabled by defining TAG_FREE_LIST_CHECK_EN.

module per32_5 (
  input  logic [31:0] mask,
  output logic [4:0]  tag,
  output logic        valid
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    tag   = 5'd0;
    valid = |mask;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i]) tag = 5'(i);
    end
  end

endmodule

module tag_free_list #(
  parameter logic [31:0] RESET_FREE_MASK = 32'hFFFF_FFFF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       alloc_req,
  output logic       alloc_ready,
  output logic [4:0] alloc_tag,
  input  logic       free_valid,
  input  logic [4:0] free_tag,
  input  logic       flush,
  output logic [5:0] busy_count,
  output logic       full,
  output logic       err
);

  localparam int unsigned NUM_TAGS = 32;

  function automatic int unsigned popcount32(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

  localparam logic [5:0] RESET_BUSY = 6'(NUM_TAGS - popcount32(RESET_FREE_MASK));
  localparam logic       RESET_FULL = (RESET_BUSY == 6'(NUM_TAGS));

  logic [31:0] free_mask;
  logic [31:0] free_mask_next;
  logic [5:0]  busy_next;
  logic        full_next;
  logic        err_next;
  logic        alloc_fire;
  logic        same_tag;
  logic        alloc_eff;
  logic        free_dec;

  per32_5 u_enc (
    .mask  (free_mask),
    .tag   (alloc_tag),
    .valid (alloc_ready)
  );

  // Same-tag alloc+free only happens on a double free; the free wins and the alloc is void.
  always_comb begin
    free_mask_next = free_mask;
    busy_next      = busy_count;
    err_next       = err;
    alloc_fire     = alloc_req & alloc_ready;
    same_tag       = alloc_fire & free_valid & (free_tag == alloc_tag);
    alloc_eff      = alloc_fire & ~same_tag;
    free_dec       = free_valid & ~free_mask[free_tag];
    if (flush) begin
      free_mask_next = RESET_FREE_MASK;
      busy_next      = RESET_BUSY;
    end else begin
      if (alloc_eff)  free_mask_next[alloc_tag] = 1'b0;
      if (free_valid) free_mask_next[free_tag]  = 1'b1;
      busy_next = busy_count + 6'(alloc_eff) - 6'(free_dec);
`ifdef TAG_FREE_LIST_CHECK_EN
      if ((free_valid & free_mask[free_tag]) | (alloc_req & ~alloc_ready)) err_next = 1'b1;
`endif
    end
    full_next = (busy_next == 6'(NUM_TAGS));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      free_mask  <= RESET_FREE_MASK;
      busy_count <= RESET_BUSY;
      full       <= RESET_FULL;
      err        <= 1'b0;
    end else begin
      free_mask  <= free_mask_next;
      busy_count <= busy_next;
      full       <= full_next;
      err        <= err_next;
    end
  end

endmodule

// File: tb/tb_tag_free_list.sv
// Self-checking bench for tag_free_list: default-mask instance plus a partial-mask instance.

module tb_tag_free_list;

`ifdef TAG_FREE_LIST_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST, alloc_req, free_valid, flush;
  logic [4:0] free_tag;
  logic       alloc_ready, full, err;
  logic [4:0] alloc_tag;
  logic [5:0] busy_count;

  logic       rst_p, alloc_req_p, free_valid_p, flush_p;
  logic [4:0] free_tag_p;
  logic       alloc_ready_p, full_p, err_p;
  logic [4:0] alloc_tag_p;
  logic [5:0] busy_count_p;

  int passed = 0;
  int total  = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_tag;

  always #5 CLK = ~CLK;

  tag_free_list dut (
    .CLK(CLK), .RST(RST), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag), .free_valid(free_valid), .free_tag(free_tag),
    .flush(flush), .busy_count(busy_count), .full(full), .err(err)
  );

  tag_free_list #(.RESET_FREE_MASK(32'hFFFF_FF00)) dut_p (
    .CLK(CLK), .RST(rst_p), .alloc_req(alloc_req_p), .alloc_ready(alloc_ready_p),
    .alloc_tag(alloc_tag_p), .free_valid(free_valid_p), .free_tag(free_tag_p),
    .flush(flush_p), .busy_count(busy_count_p), .full(full_p), .err(err_p)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RST = 0; alloc_req = 0; free_valid = 0; free_tag = 0; flush = 0;
    rst_p = 0; alloc_req_p = 0; free_valid_p = 0; free_tag_p = 0; flush_p = 0;
  endtask

  task automatic test_reset();
    idle();
    RST = 1; rst_p = 1;
    tick();
    idle();
    total++; if (busy_count !== 6'd0) $display("FAIL reset_busy got %0d want 0", busy_count); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else passed++;
    total++; if (alloc_ready !== 1'b1 || alloc_tag !== 5'd0)
      $display("FAIL reset_offer got ready=%b tag=%0d want 1/0", alloc_ready, alloc_tag); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
  endtask

  // 32 back-to-back allocs issue tags in ascending order.
  task automatic test_alloc_all();
    for (int i = 0; i < 32; i++) exp_q.push_back(5'(i));
    alloc_req = 1;
    for (int i = 0; i < 32; i++) begin
      exp_tag = exp_q.pop_front();
      total++; if (alloc_ready !== 1'b1 || alloc_tag !== exp_tag)
        $display("FAIL alloc_seq[%0d] got ready=%b tag=%0d want 1/%0d", i, alloc_ready, alloc_tag, exp_tag);
      else passed++;
      tick();
    end
    alloc_req = 0;
    total++; if (busy_count !== 6'd32 || full !== 1'b1)
      $display("FAIL alloc_full got busy=%0d full=%b want 32/1", busy_count, full); else passed++;
    total++; if (alloc_ready !== 1'b0) $display("FAIL alloc_empty got ready=%b want 0", alloc_ready); else passed++;
  endtask

  task automatic test_free_reuse();
    free_valid = 1; free_tag = 5'd7;
    tick();
    free_valid = 0;
    total++; if (alloc_ready !== 1'b1 || alloc_tag !== 5'd7)
      $display("FAIL reuse_offer got ready=%b tag=%0d want 1/7", alloc_ready, alloc_tag); else passed++;
    total++; if (busy_count !== 6'd31 || full !== 1'b0)
      $display("FAIL reuse_busy got busy=%0d full=%b want 31/0", busy_count, full); else passed++;
    alloc_req = 1; free_valid = 1; free_tag = 5'd3;
    tick();
    idle();
    total++; if (busy_count !== 6'd31) $display("FAIL swap_busy got %0d want 31", busy_count); else passed++;
    total++; if (alloc_tag !== 5'd3) $display("FAIL swap_offer got %0d want 3", alloc_tag); else passed++;
  endtask

  task automatic test_alloc_free_mix();
    RST = 1; tick(); idle();
    alloc_req = 1;
    repeat (5) tick();
    alloc_req = 0;
    total++; if (busy_count !== 6'd5 || alloc_tag !== 5'd5)
      $display("FAIL mix_pre got busy=%0d tag=%0d want 5/5", busy_count, alloc_tag); else passed++;
    alloc_req = 1; free_valid = 1; free_tag = 5'd2;
    tick();
    free_valid = 0; alloc_req = 0;
    total++; if (alloc_tag !== 5'd2 || busy_count !== 6'd5)
      $display("FAIL mix_offer got tag=%0d busy=%0d want 2/5", alloc_tag, busy_count); else passed++;
    alloc_req = 1;
    tick();
    alloc_req = 0;
    total++; if (alloc_tag !== 5'd6 || busy_count !== 6'd6)
      $display("FAIL mix_bit5 got tag=%0d busy=%0d want 6/6", alloc_tag, busy_count); else passed++;
  endtask

  // Tags 0..6 except none free below 6; tag 9 is free here.
  task automatic test_double_free();
    free_valid = 1; free_tag = 5'd9;
    tick();
    free_valid = 0;
    total++; if (busy_count !== 6'd6 || alloc_tag !== 5'd6)
      $display("FAIL dfree_state got busy=%0d tag=%0d want 6/6", busy_count, alloc_tag); else passed++;
    total++; if (err !== CHK) $display("FAIL dfree_err got %b want %b", err, CHK); else passed++;
    flush = 1; alloc_req = 1; free_valid = 1; free_tag = 5'd1;
    tick();
    idle();
    total++; if (busy_count !== 6'd0 || alloc_tag !== 5'd0)
      $display("FAIL flush_state got busy=%0d tag=%0d want 0/0", busy_count, alloc_tag); else passed++;
    total++; if (err !== CHK) $display("FAIL flush_err got %b want %b", err, CHK); else passed++;
    alloc_req = 1; free_valid = 1; free_tag = 5'd0;
    tick();
    idle();
    total++; if (busy_count !== 6'd0 || alloc_tag !== 5'd0)
      $display("FAIL same_tag got busy=%0d tag=%0d want 0/0", busy_count, alloc_tag); else passed++;
  endtask

  task automatic test_midstream_reset();
    alloc_req = 1;
    repeat (3) tick();
    RST = 1; alloc_req = 1; free_valid = 1; free_tag = 5'd1;
    tick();
    idle();
    total++; if (busy_count !== 6'd0 || alloc_tag !== 5'd0 || alloc_ready !== 1'b1)
      $display("FAIL mid_rst got busy=%0d tag=%0d ready=%b want 0/0/1", busy_count, alloc_tag, alloc_ready);
    else passed++;
    total++; if (err !== 1'b0 || full !== 1'b0)
      $display("FAIL mid_rst_flags got err=%b full=%b want 0/0", err, full); else passed++;
  endtask

  task automatic test_reset_mask();
    rst_p = 1; tick(); rst_p = 0;
    total++; if (busy_count_p !== 6'd8 || alloc_tag_p !== 5'd8)
      $display("FAIL pmask_reset got busy=%0d tag=%0d want 8/8", busy_count_p, alloc_tag_p); else passed++;
    for (int i = 0; i < 10; i++) exp_q.push_back(5'(8 + i));
    alloc_req_p = 1;
    for (int i = 0; i < 10; i++) begin
      exp_tag = exp_q.pop_front();
      total++; if (alloc_tag_p !== exp_tag)
        $display("FAIL pmask_seq[%0d] got %0d want %0d", i, alloc_tag_p, exp_tag); else passed++;
      tick();
    end
    total++; if (busy_count_p !== 6'd18) $display("FAIL pmask_busy got %0d want 18", busy_count_p); else passed++;
    flush_p = 1;
    tick();
    idle();
    total++; if (busy_count_p !== 6'd8 || alloc_tag_p !== 5'd8)
      $display("FAIL pmask_flush got busy=%0d tag=%0d want 8/8", busy_count_p, alloc_tag_p); else passed++;
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_alloc_all();
    test_free_reuse();
    test_alloc_free_mix();
    test_double_free();
    test_midstream_reset();
    test_reset_mask();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
